multiplier_seq_32bit: RTL and testbench
=======================================

Name: multiplier_seq_32bit

Overview:
- Multi-cycle radix-2 shift-and-add multiplier. It is the addition-side counterpart of the team's 2's-complement subtraction datapath.
- Serves the RV32M multiply group (MUL, MULH, MULHSU, MULHU) for the upcoming multi-cycle core.
- Accepts one operation per start pulse. Iterates one partial-product add per clock and returns the selected 32-bit half of the 64-bit product.
- Sits beside the ALU in EX and stalls the pipeline while busy is high.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  00=MUL, 01=MULH, 10=MULHSU, 11=MULHU (RV32M funct3[1:0] encoding).
- a  input  32  multiplicand (rs1).
- b  input  32  multiplier (rs2).
- busy  output  1  high while an operation is in flight (BUSY state).
- done  output  1  one-cycle pulse; result valid from this cycle onward.
- result  output  32  low word for MUL, high word otherwise; held until the next done.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, internal accumulator and operand registers=0.
- Reset asserted mid-operation aborts the operation, and no done is produced.
- States:
  - IDLE: on start=1, capture the operands and go to BUSY. Otherwise stay.
  - BUSY: 32 iterations, counter 0..31. After the iteration with counter=31, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: if start is sampled at edge k, busy=1 for cycles k+1..k+32 and done=1 in cycle k+33. A new start is accepted in the cycle after done (IDLE). Back-to-back throughput is one operation per 34 cycles.
- start while in BUSY or DONE is ignored; nothing is queued.
- a, b and op are captured at the start edge. Later changes to the inputs have no effect on the in-flight operation.
- Sign handling at capture:
  - a_neg = a[31] for MULH/MULHSU; b_neg = b[31] for MULH only.
  - Negative operands are replaced by their magnitude (two's-complement negation). 0x80000000 yields the unsigned magnitude 0x80000000.
  - neg_result = a_neg XOR b_neg, stored for the whole operation.
- Iteration:
  - 64-bit register {hi, lo}, with lo initialised to |b| and hi to 0.
  - Each cycle: if lo[0]=1 then sum = hi + |a| (33-bit, carry kept), else sum = hi. Then {hi, lo} = {carry, sum, lo} >> 1.
- Completion (last BUSY cycle):
  - If neg_result, the 64-bit product is negated (~P + 1 over 64 bits, carry propagated from low to high word).
  - result is loaded with P[31:0] for MUL and P[63:32] otherwise.
  - result updates only on this edge and on reset.
- MUL ignores sign: it uses the raw operands with a_neg = b_neg = 0, since the low word is sign-agnostic.
- Zero operands take the full 32 iterations; there is no early termination.

Decomposition:
- Shared package (mul_pkg): op encodings (MUL_OP_MUL/MULH/MULHSU/MULHU), state encoding (S_IDLE, S_BUSY, S_DONE), and the constant ITERATIONS=32.
- Sub-module: reuse the existing fulladder_32bit for the per-iteration hi + |a| add, with cin=0 and cout giving the 33rd bit.
- Operand magnitude and final negation stay in this module as plain two's-complement logic.

Test Plan:
- MUL a=7, b=6, start at edge 0 -> busy high cycles 1..32, done pulse in cycle 33, result=0x0000002A.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> product 0xFFFFFFFE_00000001, result=0xFFFFFFFE. Same operands with MUL -> result=0x00000001.
- MULH a=0x80000000, b=0x80000000 -> result=0x40000000. MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0x00000000.
- MULHSU a=0xFFFFFFFF (-1), b=0x00000002 -> product 0xFFFFFFFF_FFFFFFFE, result=0xFFFFFFFF. MULH a=0xFFFFFFFE, b=0x00000003 -> result=0xFFFFFFFF.
- Start MUL 5*5, pulse start again at cycle 10 with a=9, b=9 and change a/b/op -> second start ignored, done in cycle 33 with result=0x00000019, exactly one done pulse.
- Start MUL 3*4, drive rst_n low at cycle 15 for one cycle -> busy, done and result go 0 immediately. No done follows. A subsequent start of 3*4 completes in 33 cycles with result=0x0000000C.

Source files
------------

// File: rtl/multiplier_seq_32bit_pkg.sv
// Shared definitions for the sequential RV32M multiplier.
//   - op encodings (RV32M funct3[1:0])
//   - FSM state encoding
//   - iteration count and widths
package mul_pkg;

  localparam int XLEN       = 32;
  localparam int CNT_W      = 5;
  localparam int ITERATIONS = 32;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/fulladder_32bit.sv
// 32-bit adder with carry in/out, used for the per-iteration partial
// product accumulate.
//   a, b  : 32-bit addends
//   cin   : carry in
//   sum   : 32-bit sum
//   cout  : carry out (33rd bit of the sum)
module fulladder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b} + {32'b0, cin};
  assign sum      = full_sum[31:0];
  assign cout     = full_sum[32];

endmodule

// File: rtl/multiplier_seq_32bit.sv
// Multi-cycle radix-2 shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
// One partial-product add per clock, 32 iterations, then a one-cycle done.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request pulse, only sampled in IDLE
//   op         : 00=MUL 01=MULH 10=MULHSU 11=MULHU
//   a, b       : multiplicand (rs1), multiplier (rs2), captured on start
//   busy       : high while iterating
//   done       : one-cycle pulse when result is updated
//   result     : selected product half, held until the next done
//   state_dbg  : current FSM state
//
// Handshake: start is a request accepted only when busy=0 and done=0
// (IDLE); there is no backpressure and no queuing. done marks the single
// cycle in which a freshly computed result first appears on result.
module multiplier_seq_32bit
  import mul_pkg::*;
#(
  parameter int XLEN_P  = XLEN,
  parameter int CNT_W_P = CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [XLEN_P-1:0] a,
  input  logic [XLEN_P-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [XLEN_P-1:0] result,
  output state_e            state_dbg
);

  state_e state_q, state_d;

  logic [CNT_W_P-1:0]  cnt_q;
  logic [XLEN_P-1:0]   hi_q, lo_q;
  logic [XLEN_P-1:0]   mag_a_q;
  logic                neg_q;
  logic [1:0]          op_q;
  logic [XLEN_P-1:0]   result_q;

  // Operand conditioning at capture time
  logic                a_neg, b_neg;
  logic [XLEN_P-1:0]   a_mag, b_mag;

  // Iteration datapath
  logic [XLEN_P-1:0]   addend;
  logic [XLEN_P-1:0]   sum;
  logic                cout;
  logic [2*XLEN_P-1:0] p_next;
  logic [2*XLEN_P-1:0] p_final;
  logic                last_iter;

  always_comb begin
    a_neg = a[XLEN_P-1] && (op == MUL_OP_MULH || op == MUL_OP_MULHSU);
    b_neg = b[XLEN_P-1] && (op == MUL_OP_MULH);
    // Negating 0x80000000 wraps back to 0x80000000, which is exactly the
    // unsigned magnitude we want.
    a_mag = a_neg ? ((~a) + XLEN_P'(1)) : a;
    b_mag = b_neg ? ((~b) + XLEN_P'(1)) : b;
  end

  assign addend = lo_q[0] ? mag_a_q : '0;

  fulladder_32bit u_add (
    .a    (hi_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Shift right by one with the adder carry landing in the top bit.
  assign p_next    = {cout, sum, lo_q[XLEN_P-1:1]};
  assign p_final   = neg_q ? ((~p_next) + (2*XLEN_P)'(1)) : p_next;
  assign last_iter = (cnt_q == CNT_W_P'(ITERATIONS - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state and outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mag_a_q  <= '0;
      neg_q    <= 1'b0;
      op_q     <= 2'b00;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= b_mag;
            mag_a_q <= a_mag;
            neg_q   <= a_neg ^ b_neg;
            op_q    <= op;
          end
        end
        S_BUSY: begin
          {hi_q, lo_q} <= p_next;
          cnt_q        <= cnt_q + CNT_W_P'(1);
          if (last_iter) begin
            result_q <= (op_q == MUL_OP_MUL) ? p_final[XLEN_P-1:0]
                                             : p_final[2*XLEN_P-1:XLEN_P];
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multiplier_seq_32bit.sv
// Directed testbench for multiplier_seq_32bit.
module tb_multiplier_seq_32bit;
  import mul_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  state_e      state_dbg;

  int checks;
  int errors;

  multiplier_seq_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation starting from a point #1 after a rising edge.
  // Inputs are scrambled right after the start edge to prove capture.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp,
                        input string name);
    int busy_cnt;
    int early_done;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    busy_cnt = 0; early_done = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b0) early_done++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy_cnt != 32 || early_done != 0) begin
      errors++;
      $display("FAIL %s busy_window: busy_cycles=%0d early_done=%0d, required 32/0",
               name, busy_cnt, early_done);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b busy=%b, required 1/0", name, done, busy);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s result: got %h, required %h", name, result, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b result=%h, required 0/0/%h",
               name, done, busy, result, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b result=%h state=%0d, required 0/0/0/IDLE",
               busy, done, result, state_dbg);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    run_op(MUL_OP_MUL, 32'd7, 32'd6, 32'h0000002A, "mul_7x6");
    run_op(MUL_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
    run_op(MUL_OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_max");
    run_op(MUL_OP_MUL, 32'h0, 32'h12345678, 32'h0, "mul_zero");
  endtask

  task automatic test_signed();
    run_op(MUL_OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_minmin");
    run_op(MUL_OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1m1");
    run_op(MUL_OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, "mulhsu_m1x2");
    run_op(MUL_OP_MULH, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, "mulh_m2x3");
    // MULHSU treats b as unsigned: -1 * 0xFFFFFFFF = -(2^32-1)
    run_op(MUL_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1xmax");
  endtask

  task automatic test_ignored_start();
    int done_cnt;
    int done_cyc;
    logic [31:0] res;
    op = MUL_OP_MUL; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0; done_cyc = -1; res = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 9) begin
        start = 1'b1; a = 32'd9; b = 32'd9; op = MUL_OP_MULH;
      end
      if (c == 10) start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
        res = result;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 33) begin
      errors++;
      $display("FAIL ignored_start_done: pulses=%0d cycle=%0d, required 1/33",
               done_cnt, done_cyc);
    end
    checks++;
    if (res !== 32'h00000019) begin
      errors++;
      $display("FAIL ignored_start_result: got %h, required 00000019", res);
    end
  endtask

  task automatic test_back_to_back();
    op = MUL_OP_MULHU; a = 32'h00010000; b = 32'h00030000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) begin
      @(posedge clk); #1;
    end
    // Now in the done cycle: a start here must be ignored.
    checks++;
    if (done !== 1'b1 || result !== 32'h00000003) begin
      errors++;
      $display("FAIL b2b_first: done=%b result=%h, required 1/00000003", done, result);
    end
    start = 1'b1; op = MUL_OP_MUL; a = 32'd100; b = 32'd100;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL b2b_start_in_done: busy=%b state=%0d, required 0/IDLE", busy, state_dbg);
    end
    // Immediate start in the idle cycle after done is accepted.
    run_op(MUL_OP_MUL, 32'd1000, 32'd1000, 32'h000F4240, "b2b_second");
    run_op(MUL_OP_MULHU, 32'h80000000, 32'h00000004, 32'h00000002, "b2b_third");
  endtask

  task automatic test_reset_abort();
    int done_cnt;
    op = MUL_OP_MUL; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: busy=%b, required 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL abort_reset_now: busy=%b done=%b result=%h state=%0d, required 0/0/0/IDLE",
               busy, done, result, state_dbg);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) done_cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL abort_no_done: active_cycles=%0d, required 0", done_cnt);
    end
    run_op(MUL_OP_MUL, 32'd3, 32'd4, 32'h0000000C, "abort_restart");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mul();
    test_signed();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
